// File: rtl/seq_alu.sv
// seq_alu: registered integer ALU with valid/ready handshakes on both sides.
// Add, sub, logic and shift finish one cycle after accept. Unsigned multiply,
// divide and remainder iterate over WIDTH cycles, one bit per cycle.
//
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   enable             acceptance gate (in-flight op always completes)
//   in_valid/in_ready  operand handshake; in_ready = enable && idle
//   Operation          4-bit opcode, sampled on accept
//   a_operand          operand A
//   b_operand          operand B / shift amount
//   out_valid/out_ready result handshake; result held until out_ready
//   ALU_Output         registered result
//   Exception, Overflow, Underflow  registered flags for ALU_Output
//   busy               an operation is in flight or awaiting pickup
module seq_alu #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] a_operand,
  input  logic [WIDTH-1:0] b_operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Output,
  output logic             Exception,
  output logic             Overflow,
  output logic             Underflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3, OP_DIV = 4'd4,
    OP_AND = 4'd5, OP_OR  = 4'd6, OP_XOR = 4'd7, OP_NOT = 4'd8,
    OP_SHL = 4'd9, OP_SHR = 4'd10, OP_REM = 4'd11
  } op_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  // Shared iteration registers.
  //   MUL: {hi_q, lo_q} is the 2*WIDTH accumulator, lo_q starts as the
  //        multiplier and shifts out one bit per cycle; opb_q = multiplicand.
  //   DIV/REM: hi_q = partial remainder, lo_q = dividend shifting out while
  //        quotient bits shift in; opb_q = divisor.
  logic [WIDTH-1:0] hi_q, lo_q, opb_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q, ovf_q, unf_q;

  logic             accept;
  logic             is_iter;
  logic             b_zero;

  assign in_ready   = enable && (state_q == IDLE);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign ALU_Output = result_q;
  assign Exception  = exc_q;
  assign Overflow   = ovf_q;
  assign Underflow  = unf_q;

  assign b_zero  = (b_operand == '0);
  assign is_iter = (Operation == OP_MUL) ||
                   (((Operation == OP_DIV) || (Operation == OP_REM)) && !b_zero);

  // ---------------------------------------------------------------------------
  // Single-cycle results (also covers divide-by-zero and illegal opcodes)
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] quick_res;
  logic             quick_exc, quick_ovf, quick_unf;

  assign add_sum = {1'b0, a_operand} + {1'b0, b_operand};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    quick_res = '0;
    quick_exc = 1'b0;
    quick_ovf = 1'b0;
    quick_unf = 1'b0;
    case (Operation)
      OP_ADD: begin
        quick_res = add_sum[WIDTH-1:0];
        quick_ovf = add_sum[WIDTH];
      end
      OP_SUB: begin
        quick_res = a_operand - b_operand;
        quick_unf = (a_operand < b_operand);
      end
      OP_AND: quick_res = a_operand & b_operand;
      OP_OR:  quick_res = a_operand | b_operand;
      OP_XOR: quick_res = a_operand ^ b_operand;
      OP_NOT: quick_res = ~a_operand;
      OP_SHL: quick_res = a_operand << b_operand[SHW-1:0];
      OP_SHR: quick_res = a_operand >> b_operand[SHW-1:0];
      // Only reached with b == 0; the b != 0 case iterates instead.
      OP_DIV: begin
        quick_res = '1;
        quick_exc = 1'b1;
      end
      OP_REM: begin
        quick_res = a_operand;
        quick_exc = 1'b1;
      end
      // MUL never takes this path; illegal opcodes report result 0.
      OP_MUL:  quick_res = '0;
      default: quick_exc = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration step of shift-add multiply and restoring division
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
  logic [WIDTH:0]   div_shift, div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_next, div_lo_next;

  always_comb begin
    // Add the multiplicand when the current multiplier bit is set, then
    // shift the whole accumulator right; the carry becomes the new top bit.
    mul_sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : '0)};
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Bring down the next dividend bit; subtract the divisor if it fits.
    // The partial remainder is always < divisor, so WIDTH+1 bits suffice.
    div_shift   = {hi_q, lo_q[WIDTH-1]};
    div_trial   = div_shift - {1'b0, opb_q};
    div_ge      = (div_shift >= {1'b0, opb_q});
    div_hi_next = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_next = {lo_q[WIDTH-2:0], div_ge};
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = is_iter ? CALC : DONE;
      CALC: if (cnt_q == '0) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= only, so every register sees
  // the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q <= Operation;
            if (is_iter) begin
              cnt_q <= SHW'(WIDTH - 1);
              hi_q  <= '0;
              if (Operation == OP_MUL) begin
                lo_q  <= b_operand;
                opb_q <= a_operand;
              end else begin
                lo_q  <= a_operand;
                opb_q <= b_operand;
              end
            end else begin
              result_q <= quick_res;
              exc_q    <= quick_exc;
              ovf_q    <= quick_ovf;
              unf_q    <= quick_unf;
            end
          end
        end
        CALC: begin
          if (op_q == OP_MUL) begin
            hi_q <= mul_hi_next;
            lo_q <= mul_lo_next;
          end else begin
            hi_q <= div_hi_next;
            lo_q <= div_lo_next;
          end
          if (cnt_q == '0) begin
            exc_q <= 1'b0;
            unf_q <= 1'b0;
            if (op_q == OP_MUL) begin
              result_q <= mul_lo_next;
              ovf_q    <= |mul_hi_next;
            end else begin
              result_q <= (op_q == OP_REM) ? div_hi_next : div_lo_next;
              ovf_q    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - SHW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=64): directed vector table, a few
// hand-written handshake/reset sequences, and random ops against a
// plain-arithmetic reference model. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_seq_alu;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   Operation;
  logic [W-1:0] a_operand, b_operand;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_Output;
  logic         Exception, Overflow, Underflow;
  logic         busy;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .Operation(Operation),
    .a_operand(a_operand), .b_operand(b_operand),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_Output(ALU_Output),
    .Exception(Exception), .Overflow(Overflow), .Underflow(Underflow),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: direct arithmetic on the operation's definition.
  // Flags returned as {Exception, Overflow, Underflow}.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic [2:0] f, output int lat);
    logic [2*W-1:0] p;
    logic [W:0]     s;
    int             sh;
    r = '0; f = 3'b000; lat = 1;
    sh = int'(b % W);
    case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; f[1] = s[W]; end
      4'd2: begin r = a - b; f[0] = (a < b); end
      4'd3: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = p[W-1:0]; f[1] = (p[2*W-1:W] != 0); lat = W + 1;
      end
      4'd4:  if (b == 0) begin r = '1; f[2] = 1'b1; end else begin r = a / b; lat = W + 1; end
      4'd11: if (b == 0) begin r = a;  f[2] = 1'b1; end else begin r = a % b; lat = W + 1; end
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = a ^ b;
      4'd8:  r = ~a;
      4'd9:  r = a << sh;
      4'd10: r = a >> sh;
      default: f[2] = 1'b1;
    endcase
  endfunction

  // Issue one op from idle, wait for the result, consume it.
  // lat counts rising edges from the cycle in_valid is presented until
  // out_valid is seen.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit drop_en, output logic [W-1:0] res,
                        output logic [2:0] flg, output int lat);
    check({name, "_in_ready"}, W'(in_ready), W'(1));
    Operation = op; a_operand = a; b_operand = b; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    if (drop_en) enable = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      cyc();
      lat++;
    end
    check({name, "_timeout"}, W'(out_valid), W'(1));
    res = ALU_Output;
    flg = {Exception, Overflow, Underflow};
    check({name, "_in_ready_busy"}, W'(in_ready), W'(0));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    enable = 1'b1;
    check({name, "_out_valid_drop"}, W'(out_valid), W'(0));
  endtask

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [2:0]   flg;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input string n, input logic [3:0] op,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] res, input logic [2:0] flg,
                                  input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.res = res; v.flg = flg; v.lat = lat;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [W-1:0] res, mres;
    logic [2:0]   flg, mflg;
    int           lat, mlat;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Operation = '0; a_operand = '0; b_operand = '0;
    @(negedge clk);
    cyc();
    cyc();
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_result", ALU_Output, '0);
    check("rst_flags", W'({Exception, Overflow, Underflow}), W'(0));
    rst_n = 1'b1;
    cyc();
    check("rst_in_ready", W'(in_ready), W'(1));

    // ---- directed vector table ----
    add_vec("add_ovf", 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 3'b010, 1);
    add_vec("add",     4'd1, 64'd5, 64'd6, 64'd11, 3'b000, 1);
    add_vec("sub_unf", 4'd2, 64'd2, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 3'b001, 1);
    add_vec("mul_big", 4'd3, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 3'b010, 65);
    add_vec("mul_7x6", 4'd3, 64'd7, 64'd6, 64'd42, 3'b000, 65);
    add_vec("div",     4'd4, 64'd100, 64'd7, 64'd14, 3'b000, 65);
    add_vec("rem",     4'd11, 64'd100, 64'd7, 64'd2, 3'b000, 65);
    add_vec("div_z",   4'd4, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1);
    add_vec("rem_z",   4'd11, 64'd9, 64'd0, 64'd9, 3'b100, 1);
    add_vec("shl",     4'd9, 64'd1, 64'd67, 64'd8, 3'b000, 1);
    add_vec("shr",     4'd10, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 3'b000, 1);
    add_vec("and",     4'd5, 64'hF0F0, 64'hFF00, 64'hF000, 3'b000, 1);
    add_vec("or",      4'd6, 64'hF0F0, 64'hFF00, 64'hFFF0, 3'b000, 1);
    add_vec("xor",     4'd7, 64'hF0F0, 64'hFF00, 64'h0FF0, 3'b000, 1);
    add_vec("not",     4'd8, 64'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1);
    add_vec("ill13",   4'd13, 64'd5, 64'd6, 64'd0, 3'b100, 1);
    add_vec("ill0",    4'd0, 64'd5, 64'd6, 64'd0, 3'b100, 1);

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, flg, lat);
      check({vecs[i].name, "_res"}, res, vecs[i].res);
      check({vecs[i].name, "_flags"}, W'(flg), W'(vecs[i].flg));
      check({vecs[i].name, "_lat"}, W'(lat), W'(vecs[i].lat));
    end

    // ---- enable dropped mid-CALC: op still completes ----
    run_op("mul_en_drop", 4'd3, 64'd7, 64'd6, 1'b1, res, flg, lat);
    check("mul_en_drop_res", res, 64'd42);
    check("mul_en_drop_lat", W'(lat), W'(65));

    // ---- enable low in IDLE blocks acceptance ----
    enable = 1'b0; in_valid = 1'b1; Operation = 4'd1; a_operand = 64'd1; b_operand = 64'd1;
    check("en_low_in_ready", W'(in_ready), W'(0));
    cyc();
    cyc();
    check("en_low_busy", W'(busy), W'(0));
    check("en_low_out_valid", W'(out_valid), W'(0));
    in_valid = 1'b0; enable = 1'b1;

    // ---- out_ready while idle is ignored ----
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("idle_out_ready_busy", W'(busy), W'(0));

    // ---- hold out_ready low 5 cycles; queued producer waits ----
    Operation = 4'd1; a_operand = 64'd3; b_operand = 64'd4; in_valid = 1'b1;
    cyc();
    // Producer immediately presents the next op and holds it.
    Operation = 4'd2; a_operand = 64'd10; b_operand = 64'd1;
    check("hold_valid", W'(out_valid), W'(1));
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("hold_res", ALU_Output, 64'd7);
      check("hold_out_valid", W'(out_valid), W'(1));
      check("hold_in_ready", W'(in_ready), W'(0));
      check("hold_flags", W'({Exception, Overflow, Underflow}), W'(0));
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("hold_release_in_ready", W'(in_ready), W'(1));
    cyc();
    in_valid = 1'b0;
    check("queued_valid", W'(out_valid), W'(1));
    check("queued_res", ALU_Output, 64'd9);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // ---- reset mid-MUL ----
    Operation = 4'd3; a_operand = 64'd3; b_operand = 64'd5; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) cyc();
    check("midmul_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    cyc();
    check("midmul_rst_out_valid", W'(out_valid), W'(0));
    check("midmul_rst_result", ALU_Output, '0);
    check("midmul_rst_busy", W'(busy), W'(0));
    check("midmul_rst_in_ready", W'(in_ready), W'(1));
    rst_n = 1'b1;
    cyc();
    check("midmul_after_valid", W'(out_valid), W'(0));

    // ---- random ops against the reference model ----
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      if (n % 5 == 0) rop = 4'(3 + (n % 3));
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 200));
        2: rb = {32'd0, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 1000));
      model(rop, ra, rb, mres, mflg, mlat);
      run_op("rnd", rop, ra, rb, 1'b0, res, flg, lat);
      check($sformatf("rnd%0d_op%0d_res", n, rop), res, mres);
      check($sformatf("rnd%0d_op%0d_flags", n, rop), W'(flg), W'(mflg));
      check($sformatf("rnd%0d_op%0d_lat", n, rop), W'(lat), W'(mlat));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
